// File: rtl/skid_buffer_if.sv
// Ready/valid handshake bundle for skid_buffer: producer-side input and consumer-side output.
// The master modport is the environment around the buffer; the slave modport is the buffer itself.
interface skid_buffer_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready
   );
endinterface

// File: rtl/skid_buffer.sv
// Two-entry ready/valid stage with registered in_ready/out_valid/out_data.
// Breaks the combinational ready path while sustaining one transfer per cycle.
module skid_buffer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   skid_buffer_if.slave bus,
   output logic [1:0]  occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t                state_p0;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] main_p0;
   logic [DATA_WIDTH-1:0] skid_p0;
   logic                  in_fire;
   logic                  out_fire;
   logic                  ld_main_in;
   logic                  ld_main_skid;
   logic                  ld_skid;

   // Every output is decoded from registered state only.
   assign bus.in_ready  = (state_p0 != FULL);
   assign bus.out_valid = (state_p0 != EMPTY);
   assign bus.out_data  = main_p0;

   always_comb begin
      occupancy = 2'd0;
      case (state_p0)
         BUSY:    occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   assign in_fire  = bus.in_valid & bus.in_ready;
   assign out_fire = bus.out_valid & bus.out_ready;

   always_comb begin
      state_nxt    = state_p0;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
      case (state_p0)
         EMPTY: begin
            if (in_fire) begin
               state_nxt  = BUSY;
               ld_main_in = 1'b1;
            end
         end
         BUSY: begin
            if (in_fire && !out_fire) begin
               state_nxt = FULL;
               ld_skid   = 1'b1;
            end else if (!in_fire && out_fire) begin
               state_nxt = EMPTY;
            end else if (in_fire && out_fire) begin
               ld_main_in = 1'b1;
            end
         end
         FULL: begin
            if (out_fire) begin
               state_nxt    = BUSY;
               ld_main_skid = 1'b1;
            end
         end
         default: state_nxt = EMPTY;
      endcase
      // Flush lets any handshake complete but throws the payload away.
      if (flush) begin
         state_nxt    = EMPTY;
         ld_main_in   = 1'b0;
         ld_main_skid = 1'b0;
         ld_skid      = 1'b0;
      end
   end

   // Stage p0: state and storage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_p0 <= EMPTY;
         main_p0  <= '0;
         skid_p0  <= '0;
      end else begin
         state_p0 <= state_nxt;
         if (ld_main_in) begin
            main_p0 <= bus.in_data;
         end else if (ld_main_skid) begin
            main_p0 <= skid_p0;
         end
         if (ld_skid) begin
            skid_p0 <= bus.in_data;
         end
      end
   end

endmodule
